// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if: bundle of the scanner, clear, game and board RAM signals around the arbiter.
//   scan_*  : scanner read window, read address and returned read data
//   clear_* : clear request pulse, busy level and done pulse
//   game_*  : game request/ack handshake with write data and captured read data
//   ram_*   : single board RAM port (address, write enable, write data, async read data)
//   master  : arbiter side; slave : the users and the RAM
interface board_ram_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2
);
    logic              scan_active;
    logic [ADDR_W-1:0] scan_rd_addr;
    logic [DATA_W-1:0] scan_rd_data;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_ack;
    logic [DATA_W-1:0] game_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        input  scan_active, scan_rd_addr, clear_start, game_req, game_we, game_addr, game_wdata, ram_rdata,
        output scan_rd_data, clear_busy, clear_done, game_ack, game_rdata, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        output scan_active, scan_rd_addr, clear_start, game_req, game_we, game_addr, game_wdata, ram_rdata,
        input  scan_rd_data, clear_busy, clear_done, game_ack, game_rdata, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the single 64x2 board RAM port between the LED scanner, a clear sequencer and the game port.
//   clk    : system clock
//   rst_n_ : asynchronous active-low reset
//   bus    : master side of board_ram_arbiter_if (scanner, clear, game and RAM signals)
// Owner priority each cycle: scanner, then clear sequencer, then game access, else idle.
module board_ram_arbiter #(
    parameter int                ADDR_W         = 6,
    parameter int                DATA_W         = 2,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n_,
    board_ram_arbiter_if.master  bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nx;
    logic              r_ack;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_por;
    logic              w_clr_own;
    logic              w_game_own;
    logic              w_last;

    // Game is gated by rst_n_ so the RAM port stays with the scanner while in reset,
    // and by r_ack so the requester gets one cycle to drop or change its request.
    assign w_clr_own  = !bus.scan_active && r_state == CLEAR;
    assign w_game_own = rst_n_ && !bus.scan_active && r_state == IDLE && bus.game_req && !r_ack;
    assign w_last     = r_clr_cnt == {ADDR_W{1'b1}};

    assign bus.ram_addr     = w_clr_own ? r_clr_cnt : w_game_own ? bus.game_addr : bus.scan_rd_addr;
    assign bus.ram_we       = w_clr_own || (w_game_own && bus.game_we);
    assign bus.ram_wdata    = w_clr_own ? CLEAR_VALUE : bus.game_wdata;
    assign bus.scan_rd_data = bus.ram_rdata;
    assign bus.clear_busy   = r_state == CLEAR;
    assign bus.clear_done   = r_done;
    assign bus.game_ack     = r_ack;
    assign bus.game_rdata   = r_rdata;

    always_ff @(posedge clk or negedge rst_n_) begin
        if (!rst_n_) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
            r_por     <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_clr_cnt <= w_clr_cnt_nx;
            r_ack     <= w_game_own;
            r_done    <= w_clr_own && w_last;
            r_por     <= 1'b0;
            if (w_game_own && !bus.game_we) r_rdata <= bus.ram_rdata;
        end
    end

    // A clear_start seen while already clearing is ignored; the counter only
    // advances in cycles the scanner leaves the port to the clear sequencer.
    always_comb begin
        w_state_nx   = r_state;
        w_clr_cnt_nx = r_clr_cnt;
        if (r_state == IDLE) begin
            if (bus.clear_start || (CLEAR_ON_RESET && r_por)) begin
                w_state_nx   = CLEAR;
                w_clr_cnt_nx = '0;
            end
        end else if (w_clr_own) begin
            w_clr_cnt_nx = r_clr_cnt + 1'b1;
            w_state_nx   = w_last ? IDLE : CLEAR;
        end
    end
endmodule
